// File: rtl/mini_fpga_fabric.sv
// Miniature bit/word-line configured FPGA fabric: LUT4 cells with optional flop, routing muxes, output pads.
// Optional scan chain through the cell flops when FABRIC_SCAN_EN is defined.

module mini_fpga_cell_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic shift,
  input  logic sin,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= shift ? sin : d;
  end
endmodule

module mini_fpga_fabric #(
  parameter  int NUM_IO     = 16,
  parameter  int NUM_LUT    = 4,
  parameter  int BL_W       = 32,
  localparam int SEL_W      = $clog2(NUM_IO + NUM_LUT + 1),
  localparam int LSEL_W     = $clog2(NUM_LUT),
  localparam int CELL_W     = 16 + 4*SEL_W + 1,
  localparam int PAD_W      = 1 + LSEL_W,
  localparam int CFG_BITS   = NUM_LUT*CELL_W + NUM_IO*PAD_W,
  localparam int NUM_FRAMES = (CFG_BITS + BL_W - 1) / BL_W
) (
  input  logic                  clk,
  input  logic                  global_resetn,
  input  logic [NUM_IO-1:0]     gfpga_pad_a2f,
  output logic [NUM_IO-1:0]     gfpga_pad_f2a,
  output logic [NUM_IO-1:0]     gfpga_pad_oe,
  input  logic [BL_W-1:0]       bl_config_region_0,
  input  logic [NUM_FRAMES-1:0] wl_config_region_0
`ifdef FABRIC_SCAN_EN
  ,
  input  logic                  scan_en,
  input  logic                  scan_mode,
  input  logic                  scan_in,
  output logic                  scan_out
`endif
);
  localparam int IOI_W = $clog2(NUM_IO);

  logic [CFG_BITS-1:0]                  cfg;
  logic [NUM_LUT-1:0][15:0]             tt;
  logic [NUM_LUT-1:0][3:0][SEL_W-1:0]   sel;
  logic [NUM_LUT-1:0]                   reg_en;
  logic [NUM_LUT-1:0]                   lut_v, ff_q, cell_out, chain_in;
  logic [NUM_IO-1:0]                    pad_oe_cfg;
  logic [NUM_IO-1:0][LSEL_W-1:0]        osel;
  logic                                 shift;

  // Config memory: no reset, bits past CFG_BITS in the last frame simply have no storage.
  for (genvar k = 0; k < CFG_BITS; k++) begin : g_cfg
    always_ff @(posedge clk) begin
      if (wl_config_region_0[k / BL_W]) cfg[k] <= bl_config_region_0[k % BL_W];
    end
  end

  for (genvar c = 0; c < NUM_LUT; c++) begin : g_cell_dec
    assign tt[c]     = cfg[c*CELL_W +: 16];
    assign reg_en[c] = cfg[c*CELL_W + CELL_W - 1];
    for (genvar k = 0; k < 4; k++) begin : g_sel
      assign sel[c][k] = cfg[c*CELL_W + 16 + k*SEL_W +: SEL_W];
    end
  end

  for (genvar p = 0; p < NUM_IO; p++) begin : g_pad_dec
    assign pad_oe_cfg[p] = cfg[NUM_LUT*CELL_W + p*PAD_W];
    assign osel[p]       = cfg[NUM_LUT*CELL_W + p*PAD_W + 1 +: LSEL_W];
  end

  // Cells evaluated in index order; a source cell j >= i is only legal when registered,
  // so it is taken straight from its flop, which keeps the netlist free of comb loops.
  always_comb begin
    logic [NUM_LUT-1:0] co;
    logic [3:0]         idx;
    int                 s, j;
    co    = '0;
    idx   = '0;
    s     = 0;
    j     = 0;
    lut_v = '0;
    for (int i = 0; i < NUM_LUT; i++) begin
      idx = '0;
      for (int k = 0; k < 4; k++) begin
        s = int'(sel[i][k]);
        if (s < NUM_IO) begin
          idx[k] = gfpga_pad_a2f[s[IOI_W-1:0]];
        end else if (s < NUM_IO + NUM_LUT) begin
          j      = s - NUM_IO;
          idx[k] = (j < i) ? co[j[LSEL_W-1:0]] : ff_q[j[LSEL_W-1:0]];
        end
      end
      lut_v[i] = tt[i][idx];
      co[i]    = reg_en[i] ? ff_q[i] : lut_v[i];
    end
    cell_out = co;
  end

`ifdef FABRIC_SCAN_EN
  assign shift    = scan_mode & scan_en;
  assign chain_in = {ff_q[NUM_LUT-2:0], scan_in};
  assign scan_out = ff_q[NUM_LUT-1];
`else
  assign shift    = 1'b0;
  assign chain_in = '0;
`endif

  mini_fpga_cell_ff u_ff [NUM_LUT-1:0] (
    .clk   (clk),
    .rst_n (global_resetn),
    .d     (lut_v),
    .shift (shift),
    .sin   (chain_in),
    .q     (ff_q)
  );

  assign gfpga_pad_oe = pad_oe_cfg & {NUM_IO{global_resetn}};

  always_comb begin
    gfpga_pad_f2a = '0;
    for (int p = 0; p < NUM_IO; p++) begin
      if (pad_oe_cfg[p] && global_resetn && (int'(osel[p]) < NUM_LUT))
        gfpga_pad_f2a[p] = cell_out[osel[p]];
    end
  end

endmodule

// File: tb/tb_mini_fpga_fabric.sv
// Self-checking bench for mini_fpga_fabric: hand tables for the mapped functions plus
// random legal configurations compared against a fixpoint-relaxation model of the fabric.

module tb_mini_fpga_fabric;
  localparam int NIO  = 16;
  localparam int NL   = 4;
  localparam int CW   = 37;
  localparam int CFGB = 196;
  localparam int PADB = 148;

  logic        clk, global_resetn;
  logic [15:0] a2f, f2a, oe;
  logic [31:0] bl;
  logic [6:0]  wl;
`ifdef FABRIC_SCAN_EN
  logic scan_en, scan_mode, scan_in, scan_out;
`endif

  int n_cmp, n_bad;
  logic [223:0]    img;
  logic [CFGB-1:0] mcfg;
  logic [3:0]      mff;

  typedef struct {
    logic [15:0] a;
    logic [15:0] ef;
    logic [15:0] eo;
  } vec_t;
  vec_t tbl[9];

  mini_fpga_fabric dut (
    .clk                (clk),
    .global_resetn      (global_resetn),
    .gfpga_pad_a2f      (a2f),
    .gfpga_pad_f2a      (f2a),
    .gfpga_pad_oe       (oe),
    .bl_config_region_0 (bl),
    .wl_config_region_0 (wl)
`ifdef FABRIC_SCAN_EN
    ,
    .scan_en            (scan_en),
    .scan_mode          (scan_mode),
    .scan_in            (scan_in),
    .scan_out           (scan_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic pool(input int s, input logic [15:0] a, input logic [3:0] co);
    int t;
    t = s - NIO;
    if (s < NIO) return a[s[3:0]];
    if (s < NIO + NL) return co[t[1:0]];
    return 1'b0;
  endfunction

  // Relax all cells NL+1 times from the flop state; legal configs are acyclic so this settles.
  task automatic model_eval(input logic [15:0] a, output logic [15:0] mf, output logic [15:0] moe,
                            output logic [3:0] lutv);
    logic [3:0]  out, nout, in;
    logic [15:0] t;
    int base, s, os;
    logic o;
    out = mff; nout = mff; lutv = '0; mf = '0; moe = '0; in = '0;
    for (int it = 0; it <= NL; it++) begin
      for (int c = 0; c < NL; c++) begin
        base = c*CW;
        t = mcfg[base +: 16];
        for (int k = 0; k < 4; k++) begin
          s = int'(mcfg[base + 16 + k*5 +: 5]);
          in[k] = pool(s, a, out);
        end
        lutv[c] = t[in];
        nout[c] = mcfg[base + CW - 1] ? mff[c] : lutv[c];
      end
      out = nout;
    end
    for (int p = 0; p < NIO; p++) begin
      o = mcfg[PADB + p*3] & global_resetn;
      os = int'(mcfg[PADB + p*3 + 1 +: 2]);
      moe[p] = o;
      mf[p]  = (o && os < NL) ? out[os[1:0]] : 1'b0;
    end
  endtask

  task automatic cycle();
    logic [15:0] f, o;
    logic [3:0]  l;
    model_eval(a2f, f, o, l);
    @(posedge clk);
    #1;
    mff = global_resetn ? l : 4'b0;
  endtask

  task automatic set_rst(input logic v);
    global_resetn = v;
    if (!v) mff = '0;
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    logic [15:0] f, o;
    logic [3:0]  l;
    model_eval(a2f, f, o, l);
    check({nm, "_f2a"}, f2a, f);
    check({nm, "_oe"}, oe, o);
  endtask

  task automatic write_frame(input logic [6:0] w, input logic [31:0] d);
    wl = w;
    bl = d;
    cycle();
    for (int r = 0; r < 7; r++)
      for (int b = 0; b < 32; b++)
        if (w[r] && (r*32 + b) < CFGB) mcfg[r*32 + b] = d[b];
    wl = '0;
  endtask

  task automatic load_img();
    logic [6:0] w;
    for (int r = 0; r < 7; r++) begin
      w = '0;
      w[r] = 1'b1;
      write_frame(w, img[r*32 +: 32]);
    end
  endtask

  task automatic cell_cfg(input int c, input logic [15:0] t, input int s0, input int s1,
                          input int s2, input int s3, input logic re);
    int b;
    b = c*CW;
    img[b +: 16]      = t;
    img[b + 16 +: 5]  = s0[4:0];
    img[b + 21 +: 5]  = s1[4:0];
    img[b + 26 +: 5]  = s2[4:0];
    img[b + 31 +: 5]  = s3[4:0];
    img[b + 36]       = re;
  endtask

  task automatic pad_cfg(input int p, input logic o, input int os);
    img[PADB + p*3]        = o;
    img[PADB + p*3 + 1 +: 2] = os[1:0];
  endtask

  task automatic and8_img();
    img = '0;
    cell_cfg(0, 16'h8000, 0, 1, 2, 3, 1'b0);
    cell_cfg(1, 16'h8000, 4, 5, 6, 7, 1'b0);
    cell_cfg(2, 16'h0008, 16, 17, 31, 31, 1'b0);
    pad_cfg(8, 1'b1, 2);
    pad_cfg(9, 1'b1, 1);
    pad_cfg(10, 1'b1, 0);
  endtask

  task automatic rand_img();
    logic [3:0] re;
    int s[4];
    int cat, j;
    img = '0;
    for (int c = 0; c < NL; c++) re[c] = 1'($urandom_range(0, 1));
    for (int c = 0; c < NL; c++) begin
      for (int k = 0; k < 4; k++) begin
        cat = int'($urandom_range(0, 3));
        j   = int'($urandom_range(0, 3));
        if (cat == 0)                   s[k] = int'($urandom_range(0, 15));
        else if (cat == 1)              s[k] = 20 + int'($urandom_range(0, 11));
        else if (j < c || re[j])        s[k] = 16 + j;
        else                            s[k] = int'($urandom_range(0, 15));
      end
      cell_cfg(c, 16'($urandom), s[0], s[1], s[2], s[3], re[c]);
    end
    for (int p = 0; p < NIO; p++) pad_cfg(p, 1'($urandom), int'($urandom_range(0, 3)));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    mff = '0; mcfg = '0; img = '0;
    global_resetn = 1'b0; a2f = '0; wl = '0; bl = '0;
`ifdef FABRIC_SCAN_EN
    scan_en = 1'b0; scan_mode = 1'b0; scan_in = 1'b0;
`endif
    // AND8 walk: pad8 = AND(a2f[7:0]), pad9 = AND(a2f[7:4]), pad10 = AND(a2f[3:0]).
    tbl[0] = '{16'h0000, 16'h0000, 16'h0700};
    tbl[1] = '{16'h0001, 16'h0000, 16'h0700};
    tbl[2] = '{16'h0003, 16'h0000, 16'h0700};
    tbl[3] = '{16'h0007, 16'h0000, 16'h0700};
    tbl[4] = '{16'h000F, 16'h0400, 16'h0700};
    tbl[5] = '{16'h001F, 16'h0400, 16'h0700};
    tbl[6] = '{16'h003F, 16'h0400, 16'h0700};
    tbl[7] = '{16'h007F, 16'h0400, 16'h0700};
    tbl[8] = '{16'h00FF, 16'h0700, 16'h0700};

    cycle(); cycle();
    check("reset_f2a", f2a, 16'h0000);
    check("reset_oe", oe, 16'h0000);

    and8_img();
    load_img();
    set_rst(1'b1);
    foreach (tbl[i]) begin
      a2f = tbl[i].a;
      #1;
      check($sformatf("and8_%0d_f2a", i), f2a, tbl[i].ef);
      check($sformatf("and8_%0d_oe", i), oe, tbl[i].eo);
    end

    // Reset hold: configure under reset with all inputs high.
    set_rst(1'b0);
    a2f = 16'h00FF;
    and8_img();
    load_img();
    check("hold_f2a", f2a, 16'h0000);
    check("hold_oe", oe, 16'h0000);
    set_rst(1'b1);
    check("release_f2a", f2a, 16'h0700);
    check("release_oe", oe, 16'h0700);

    // Frame write: frames 0 and 2 forced to ones, frame 1 keeps cell1's AND truth table.
    a2f = 16'hFFFF;
    write_frame(7'b0000101, 32'hFFFFFFFF);
    cycle();
    check("frame_f2a", f2a, 16'h0500);
    check("frame_oe", oe, 16'h0700);
    check_model("frame_model");

    // Registered buffer on cell0 driving pad0.
    a2f = '0;
    img = '0;
    cell_cfg(0, 16'hAAAA, 0, 0, 0, 0, 1'b1);
    pad_cfg(0, 1'b1, 0);
    load_img();
    cycle();
    check("reg_idle", f2a, 16'h0000);
    a2f = 16'h0001; #1;
    check("reg_latency", f2a, 16'h0000);
    cycle();
    check("reg_rise", f2a, 16'h0001);
    a2f = 16'h0000; #1;
    check("reg_hold", f2a, 16'h0001);
    cycle();
    check("reg_fall", f2a, 16'h0000);
    a2f = 16'h0001;
    cycle();
    check("reg_rise2", f2a, 16'h0001);
    set_rst(1'b0);
    check("reg_midrst_f2a", f2a, 16'h0000);
    check("reg_midrst_oe", oe, 16'h0000);
    set_rst(1'b1);
    check("reg_post_f2a", f2a, 16'h0000);
    check("reg_post_oe", oe, 16'h0001);
    cycle();
    check("reg_recover", f2a, 16'h0001);

    // Out-of-range selects read constant 0; pad15 and index 20 are the boundaries.
    img = '0;
    cell_cfg(0, 16'h5555, 31, 0, 0, 0, 1'b0);
    cell_cfg(1, 16'h5555, 20, 0, 0, 0, 1'b0);
    cell_cfg(2, 16'h5555, 15, 0, 0, 0, 1'b0);
    pad_cfg(0, 1'b1, 0);
    pad_cfg(1, 1'b1, 1);
    pad_cfg(2, 1'b1, 2);
    load_img();
    a2f = 16'hFFFF; #1;
    check("oor_hi_f2a", f2a, 16'h0003);
    check("oor_hi_oe", oe, 16'h0007);
    a2f = 16'h0000; #1;
    check("oor_lo_f2a", f2a, 16'h0007);

    // Random legal configurations against the model.
    for (int n = 0; n < 8; n++) begin
      set_rst(1'b1);
      rand_img();
      load_img();
      for (int cyc = 0; cyc < 24; cyc++) begin
        a2f = 16'($urandom);
        set_rst(($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1);
        check_model($sformatf("rand%0d_%0d", n, cyc));
        cycle();
      end
    end

`ifdef FABRIC_SCAN_EN
    set_rst(1'b0);
    set_rst(1'b1);
    scan_mode = 1'b1;
    scan_en   = 1'b1;
    scan_in = 1'b1; cycle();
    scan_in = 1'b0; cycle();
    scan_in = 1'b1; cycle();
    scan_in = 1'b1; cycle();
    scan_in = 1'b0;
    check("scan_0", {15'b0, scan_out}, 16'h0001);
    cycle();
    check("scan_1", {15'b0, scan_out}, 16'h0000);
    cycle();
    check("scan_2", {15'b0, scan_out}, 16'h0001);
    cycle();
    check("scan_3", {15'b0, scan_out}, 16'h0001);
    scan_mode = 1'b0;
    scan_en   = 1'b0;
    set_rst(1'b0);
    check("scan_rst", {15'b0, scan_out}, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
